pwm_duty_capture: RTL and testbench

- Receive-side counterpart to the RGB PWM driver: samples one PWM waveform and recovers its 8-bit duty value.
- Typical uses: loopback verification of the LED drive pins, and reading PWM from external sources.
- Instantiated once per channel (R, G, B) beside the PWM generator.
- Synchronises the input, measures the high time and period of each cycle from rising edge to rising edge, and publishes the duty with a one-cycle valid strobe.
- Flags periods out of tolerance and reports stuck-high/stuck-low inputs as 255/0.

---
 rtl/pwm_duty_capture.sv | 136 +++++++++++++
 tb/tb_pwm_duty_capture.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: recovers the 8-bit duty of one PWM channel.
// The input is synchronised and optionally inverted. High time and period are
// measured from one internal rising edge to the next. The recovered duty is
// published with a one-cycle strobe. A missing edge for TIMEOUT cycles reports
// the input as stuck, giving a duty of 255 or 0.
module pwm_duty_capture #(
  parameter int PWM_PERIOD = 256,
  parameter int PERIOD_TOL = 2,
  parameter int TIMEOUT    = 1024,
  parameter int ACTIVE_LOW = 1,
  parameter int CNT_W      = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] duty,
  output logic       duty_valid,
  output logic       locked,
  output logic       period_err
);

  // Raw pin level that maps to "active" after polarity correction. The
  // synchroniser resets to it, so a pin held active produces no false edge.
  localparam logic INVERT   = (ACTIVE_LOW != 0);
  localparam logic SYNC_RST = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PERIOD_LO = CNT_W'(PWM_PERIOD - PERIOD_TOL);
  localparam logic [CNT_W-1:0] PERIOD_HI = CNT_W'(PWM_PERIOD + PERIOD_TOL);
  localparam logic [CNT_W-1:0] DUTY_MAX  = CNT_W'(255);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t            state_reg, state_next;
  logic              sync1_reg, sync2_reg;
  logic              lvl_reg, lvl_prev_reg;
  logic [CNT_W-1:0]  p_cnt_reg, h_cnt_reg;
  logic [CNT_W-1:0]  p_inc, h_inc;
  logic              rise, timeout_hit, period_ok;
  logic              eval_ok, eval_bad, stuck;

  assign rise        = lvl_reg & ~lvl_prev_reg;
  // Counters saturate at TIMEOUT.
  assign p_inc       = (p_cnt_reg == TIMEOUT_C) ? p_cnt_reg : p_cnt_reg + ONE;
  assign h_inc       = (h_cnt_reg == TIMEOUT_C) ? h_cnt_reg : h_cnt_reg + ONE;
  // The stuck event fires on the cycle in which the period count would reach TIMEOUT.
  assign timeout_hit = (p_inc == TIMEOUT_C);
  assign period_ok   = (p_cnt_reg >= PERIOD_LO) && (p_cnt_reg <= PERIOD_HI);

  // Two-flop synchroniser, polarity correction, then edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg    <= SYNC_RST;
      sync2_reg    <= SYNC_RST;
      lvl_reg      <= 1'b1;
      lvl_prev_reg <= 1'b1;
    end else begin
      sync1_reg    <= pwm_in;
      sync2_reg    <= sync1_reg;
      lvl_reg      <= sync2_reg ^ INVERT;
      lvl_prev_reg <= lvl_reg;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state and the per-cycle event decode. A rise takes priority over a timeout.
  always_comb begin
    state_next = state_reg;
    eval_ok    = 1'b0;
    eval_bad   = 1'b0;
    stuck      = 1'b0;
    case (state_reg)
      IDLE: begin
        // The first rise only starts a measurement. No period is judged yet.
        if (rise)             state_next = MEASURE;
        else if (timeout_hit) stuck = 1'b1;
      end
      MEASURE: begin
        if (rise) begin
          eval_ok  = period_ok;
          eval_bad = ~period_ok;
        end else if (timeout_hit) begin
          stuck      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Period and high-time counters. A rise cycle counts as the first cycle of a new period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cnt_reg <= '0;
      h_cnt_reg <= '0;
    end else if (rise) begin
      p_cnt_reg <= ONE;
      h_cnt_reg <= ONE;
    end else if (stuck) begin
      p_cnt_reg <= '0;
      h_cnt_reg <= '0;
    end else begin
      p_cnt_reg <= p_inc;
      if (state_reg == MEASURE && lvl_reg) h_cnt_reg <= h_inc;
    end
  end

  // Published outputs. duty changes only together with a duty_valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty       <= 8'd0;
      duty_valid <= 1'b0;
      locked     <= 1'b0;
      period_err <= 1'b0;
    end else begin
      duty_valid <= eval_ok | stuck;
      period_err <= eval_bad;
      if (eval_ok) begin
        duty   <= (h_cnt_reg > DUTY_MAX) ? 8'hFF : h_cnt_reg[7:0];
        locked <= 1'b1;
      end else if (eval_bad) begin
        locked <= 1'b0;
      end else if (stuck) begin
        duty   <= lvl_reg ? 8'hFF : 8'h00;
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Testbench for pwm_duty_capture with default parameters (ACTIVE_LOW=1).
// Stimulus is described in "active" terms; the pin is driven inverted.
// Expected duty and period-error events are queued as each closing edge is
// driven, and they are checked by a monitor when the DUT strobes.
module tb_pwm_duty_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwm_in;
  logic [7:0] duty;
  logic       duty_valid;
  logic       locked;
  logic       period_err;

  pwm_duty_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .locked     (locked),
    .period_err (period_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] duty;
    bit         lk;
  } exp_t;

  typedef struct {
    int   high;
    int   period;
    exp_t res;
  } vec_t;

  exp_t exp_q[$];
  exp_t pend;
  exp_t mon_e;
  bit   pend_v = 1'b0;
  vec_t tbl[13];
  vec_t rv;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int r0, c0, base;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (duty_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (duty_valid || period_err) begin
      n_cmp++;
      if (duty_valid && period_err) begin
        n_bad++;
        $display("FAIL excl: duty_valid=1 period_err=1 at cyc %0d, required at most one", cyc);
      end else if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: err=%0b duty=%0d locked=%0b at cyc %0d, required no event",
                 period_err, duty, locked, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (period_err != mon_e.is_err || duty != mon_e.duty || locked != mon_e.lk) begin
          n_bad++;
          $display("FAIL event: got err=%0b duty=%0d locked=%0b, required err=%0b duty=%0d locked=%0b (cyc %0d)",
                   period_err, duty, locked, mon_e.is_err, mon_e.duty, mon_e.lk, cyc);
        end else begin
          $display("event cyc=%0d err=%0b duty=%0d locked=%0b ok", cyc, period_err, duty, locked);
        end
      end
    end
  end

  task automatic set_act(input bit a);
    pwm_in = ~a;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  task automatic wait_valid(input int target, input int budget);
    int k = 0;
    while (valid_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    if (valid_cnt < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: got %0d strobes, required %0d within %0d cycles", valid_cnt, target, budget);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_duty"}, int'(duty), 0);
    check({tag, "_valid"}, int'(duty_valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_perr"}, int'(period_err), 0);
  endtask

  // One PWM period starting with a rising edge. The rise closes the previous
  // period, so that period's expectation is queued first.
  task automatic drive_period(input vec_t v);
    if (pend_v) exp_q.push_back(pend);
    pend   = v.res;
    pend_v = 1'b1;
    for (int i = 0; i < v.period; i++) begin
      set_act(i < v.high);
      tick(1);
    end
  endtask

  initial begin
    // {high, period, {is_err, duty (held value on error), locked}}
    tbl[0]  = '{64,  256, '{1'b0, 8'd64,  1'b1}};
    tbl[1]  = '{64,  256, '{1'b0, 8'd64,  1'b1}};
    tbl[2]  = '{200, 256, '{1'b0, 8'd200, 1'b1}};
    tbl[3]  = '{200, 256, '{1'b0, 8'd200, 1'b1}};
    tbl[4]  = '{100, 300, '{1'b1, 8'd200, 1'b0}};
    tbl[5]  = '{100, 300, '{1'b1, 8'd200, 1'b0}};
    tbl[6]  = '{100, 258, '{1'b0, 8'd100, 1'b1}};
    tbl[7]  = '{100, 259, '{1'b1, 8'd100, 1'b0}};
    tbl[8]  = '{100, 254, '{1'b0, 8'd100, 1'b1}};
    tbl[9]  = '{100, 253, '{1'b1, 8'd100, 1'b0}};
    tbl[10] = '{255, 256, '{1'b0, 8'd255, 1'b1}};
    tbl[11] = '{128, 256, '{1'b0, 8'd128, 1'b1}};
    tbl[12] = '{128, 256, '{1'b0, 8'd128, 1'b1}};

    // Reset with the pin inactive (raw high).
    rst_n  = 1'b0;
    pwm_in = 1'b1;
    tick(3);
    check_zero("reset");
    exp_q.push_back('{1'b0, 8'd0, 1'b0});
    exp_q.push_back('{1'b0, 8'd0, 1'b0});
    rst_n = 1'b1;
    r0 = cyc;
    wait_valid(1, 1100);
    check("idle_stuck_first", last_valid_cyc - r0, 1024);
    r0 = last_valid_cyc;
    wait_valid(2, 1100);
    check("idle_stuck_repeat", last_valid_cyc - r0, 1024);

    // Table of periods. The first rise only starts measuring.
    for (int i = 0; i < 13; i++) drive_period(tbl[i]);

    // Hold active: this rise closes the last 128 period, then a timeout reports 255.
    exp_q.push_back(pend);
    pend_v = 1'b0;
    exp_q.push_back('{1'b0, 8'd255, 1'b0});
    base = valid_cnt;
    c0 = cyc;
    set_act(1'b1);
    wait_valid(base + 1, 50);
    check("rise_to_valid", last_valid_cyc - c0, 4);
    wait_valid(base + 2, 1200);
    // 3 cycles to the internal rise, then 1024 cycles without a new rise.
    check("active_stuck", last_valid_cyc - c0, 1027);
    tick(40);
    set_act(1'b0);
    tick(60);

    // Edges resume: the second rise relocks.
    rv = '{128, 256, '{1'b0, 8'd128, 1'b1}};
    drive_period(rv);
    drive_period(rv);

    // Reset one cycle in the middle of an active phase; the partial period is discarded.
    exp_q.push_back(pend);
    pend_v = 1'b0;
    set_act(1'b1);
    tick(100);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    tick(1);
    rst_n = 1'b1;
    tick(27);
    set_act(1'b0);
    tick(128);
    drive_period(rv);
    rv = '{64, 256, '{1'b0, 8'd64, 1'b1}};
    drive_period(rv);
    exp_q.push_back(pend);
    pend_v = 1'b0;
    set_act(1'b1);
    tick(20);
    set_act(1'b0);
    tick(20);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
